// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, instruction-memory handshake, one-entry skid buffer, IF/ID register
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   PC_EN, IFID_EN        hazard-unit enables (PC advance / IF/ID load)
//   Flush, Target_PC      ID-stage redirect
//   IM_req, IM_addr       instruction-memory request, address (held until IM_ack)
//   IM_ack, IM_rdata      instruction-memory response
//   Instr_ID, PCplus4_ID  IF/ID instruction and its PC+4
//   Valid_ID              IF/ID holds a real instruction
//   Fetch_busy            ID has no new instruction this cycle

module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_EN,
   input  logic        IFID_EN,
   input  logic        Flush,
   input  logic [31:0] Target_PC,
   output logic        IM_req,
   output logic [31:0] IM_addr,
   input  logic        IM_ack,
   input  logic [31:0] IM_rdata,
   output logic [31:0] Instr_ID,
   output logic [31:0] PCplus4_ID,
   output logic        Valid_ID,
   output logic        Fetch_busy
);

   typedef enum logic [1:0] {
      S_WAIT    = 2'd0,   // request outstanding for pc_q
      S_BUF     = 2'd1,   // fetched word parked in the skid buffer, no request
      S_DISCARD = 2'd2    // redirected, but the old request must complete first
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pend_q;
   logic [31:0] buf_instr_q;
   logic [31:0] buf_pcp4_q;
   logic [31:0] instr_q;
   logic [31:0] pcp4_q;
   logic        valid_q;

   logic        adv;
   logic [31:0] pc_plus4;

   assign adv      = PC_EN & IFID_EN;
   assign pc_plus4 = pc_q + 32'd4;   // wraps mod 2^32

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_WAIT;
         pc_q        <= RESET_PC;
         pend_q      <= 32'd0;
         buf_instr_q <= 32'd0;
         buf_pcp4_q  <= 32'd0;
         instr_q     <= NOP_INSTR;
         pcp4_q      <= 32'd0;
         valid_q     <= 1'b0;
      end else begin
         case (state_q)
            S_WAIT: begin
               if (Flush) begin
                  // Flush overrides an IF/ID stall hold.
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
                  if (IM_ack) begin
                     pc_q <= Target_PC;
                  end else begin
                     // Address must stay stable until the ack; remember the redirect.
                     pend_q  <= Target_PC;
                     state_q <= S_DISCARD;
                  end
               end else if (IM_ack && adv) begin
                  instr_q <= IM_rdata;
                  pcp4_q  <= pc_plus4;
                  valid_q <= 1'b1;
                  pc_q    <= pc_plus4;
               end else if (IM_ack) begin
                  buf_instr_q <= IM_rdata;
                  buf_pcp4_q  <= pc_plus4;
                  state_q     <= S_BUF;
               end else if (IFID_EN) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
               end
            end
            S_BUF: begin
               if (Flush) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
                  pc_q    <= Target_PC;
                  state_q <= S_WAIT;
               end else if (adv) begin
                  instr_q <= buf_instr_q;
                  pcp4_q  <= buf_pcp4_q;
                  valid_q <= 1'b1;
                  pc_q    <= pc_plus4;
                  state_q <= S_WAIT;
               end
            end
            S_DISCARD: begin
               if (Flush || IFID_EN) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
               end
               if (IM_ack) begin
                  // A redirect arriving with the ack is the newest one.
                  pc_q    <= Flush ? Target_PC : pend_q;
                  state_q <= S_WAIT;
               end else if (Flush) begin
                  pend_q <= Target_PC;
               end
            end
            default: begin
               state_q <= S_WAIT;
            end
         endcase
      end
   end

   assign IM_req     = (state_q != S_BUF);
   assign IM_addr    = pc_q;
   assign Instr_ID   = instr_q;
   assign PCplus4_ID = pcp4_q;
   assign Valid_ID   = valid_q;
   assign Fetch_busy = ((state_q == S_WAIT) && !IM_ack) || (state_q == S_DISCARD);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage

module tb_fetch_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        PC_EN, IFID_EN, Flush;
   logic [31:0] Target_PC;
   logic        IM_req, IM_ack;
   logic [31:0] IM_addr, IM_rdata;
   logic [31:0] Instr_ID, PCplus4_ID;
   logic        Valid_ID, Fetch_busy;

   logic        IM_req2, IM_ack2;
   logic [31:0] IM_addr2, IM_rdata2;
   logic [31:0] Instr_ID2, PCplus4_ID2;
   logic        Valid_ID2, Fetch_busy2;

   fetch_stage u_dut (
      .clk(clk), .rst_n(rst_n), .PC_EN(PC_EN), .IFID_EN(IFID_EN), .Flush(Flush),
      .Target_PC(Target_PC), .IM_req(IM_req), .IM_addr(IM_addr), .IM_ack(IM_ack),
      .IM_rdata(IM_rdata), .Instr_ID(Instr_ID), .PCplus4_ID(PCplus4_ID),
      .Valid_ID(Valid_ID), .Fetch_busy(Fetch_busy)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
      .clk(clk), .rst_n(rst_n), .PC_EN(1'b1), .IFID_EN(1'b1), .Flush(1'b0),
      .Target_PC(32'd0), .IM_req(IM_req2), .IM_addr(IM_addr2), .IM_ack(IM_ack2),
      .IM_rdata(IM_rdata2), .Instr_ID(Instr_ID2), .PCplus4_ID(PCplus4_ID2),
      .Valid_ID(Valid_ID2), .Fetch_busy(Fetch_busy2)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // bench-side controls, applied at each negedge by tick()
   logic        rst_v, pc_en_v, ifid_en_v, flush_v, stray_v, adv_prev;
   logic [31:0] target_v;
   int          lat;

   // memory model state
   logic        mem_busy, mem_drop;
   logic [31:0] mem_addr;
   int          mem_cnt;

   logic [63:0] exp_q[$];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, a[15:0]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      logic [63:0] e;
      @(negedge clk);
      // scoreboard: a real instruction entered IF/ID at the last edge
      if (Valid_ID === 1'b1 && adv_prev) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_eq("sb_instr", Instr_ID, e[63:32]);
            check_eq("sb_pcplus4", PCplus4_ID, e[31:0]);
         end
      end
      // instruction memory
      IM_rdata = 32'hDEAD_BEEF;
      if (!rst_v) begin
         IM_ack   = stray_v;
         mem_busy = 1'b0;
         mem_drop = 1'b0;
         exp_q.delete();
      end else begin
         IM_ack = 1'b0;
         if (IM_req) begin
            if (!mem_busy) begin
               mem_busy = 1'b1;
               mem_addr = IM_addr;
               mem_cnt  = lat - 1;
            end else begin
               check_eq("addr_stable", IM_addr, mem_addr);
            end
            if (flush_v) mem_drop = 1'b1;
            if (mem_cnt == 0) begin
               IM_ack   = 1'b1;
               IM_rdata = word_at(mem_addr);
               if (!mem_drop) exp_q.push_back({word_at(mem_addr), mem_addr + 32'd4});
               mem_busy = 1'b0;
               mem_drop = 1'b0;
            end else begin
               mem_cnt--;
            end
         end
      end
      IM_ack2   = IM_req2;
      IM_rdata2 = word_at(IM_addr2);
      rst_n     = rst_v;
      PC_EN     = pc_en_v;
      IFID_EN   = ifid_en_v;
      Flush     = flush_v;
      Target_PC = target_v;
      adv_prev  = pc_en_v & ifid_en_v;
   endtask

   task automatic t_discard(input logic [31:0] old_a, input logic [31:0] tgt1,
                            input bit two, input logic [31:0] tgt2);
      int n;
      lat = 3; flush_v = 1'b1; target_v = tgt1;
      tick();
      flush_v = 1'b0; lat = 1;
      tick();
      check_eq("disc_addr_held", IM_addr, old_a);
      check_eq("disc_valid", 32'(Valid_ID), 32'd0);
      check_eq("disc_instr", Instr_ID, 32'd0);
      check_eq("disc_busy", 32'(Fetch_busy), 32'd1);
      if (two) begin
         flush_v = 1'b1; target_v = tgt2;
         tick();
         flush_v = 1'b0;
      end
      n = 0;
      while (IM_addr === old_a && n < 10) begin
         tick();
         n++;
      end
      check_eq("disc_next_addr", IM_addr, two ? tgt2 : tgt1);
      check_eq("disc_valid_after", 32'(Valid_ID), 32'd0);
   endtask

   initial begin
      rst_v = 1'b0; pc_en_v = 1'b1; ifid_en_v = 1'b1; flush_v = 1'b0; stray_v = 1'b0;
      target_v = 32'd0; lat = 1; adv_prev = 1'b0;
      mem_busy = 1'b0; mem_drop = 1'b0; mem_addr = 32'd0; mem_cnt = 0;
      rst_n = 1'b0; PC_EN = 1'b1; IFID_EN = 1'b1; Flush = 1'b0; Target_PC = 32'd0;
      IM_ack = 1'b0; IM_rdata = 32'd0; IM_ack2 = 1'b0; IM_rdata2 = 32'd0;

      // reset state
      tick(); tick();
      check_eq("rst_valid", 32'(Valid_ID), 32'd0);
      check_eq("rst_instr", Instr_ID, 32'd0);
      check_eq("rst_pcplus4", PCplus4_ID, 32'd0);
      check_eq("rst_addr", IM_addr, 32'd0);
      check_eq("rst_req", 32'(IM_req), 32'd1);
      check_eq("rst_addr_wrap", IM_addr2, 32'hFFFF_FFFC);

      // T1: zero-wait memory, one instruction per cycle
      rst_v = 1'b1;
      tick();
      for (int k = 1; k <= 3; k++) begin
         tick();
         check_eq("t1_addr", IM_addr, 32'(4 * k));
         check_eq("t1_busy", 32'(Fetch_busy), 32'd0);
         if (k == 1) begin
            // T5: RESET_PC = 0xFFFF_FFFC wraps
            check_eq("t5_pcplus4", PCplus4_ID2, 32'd0);
            check_eq("t5_instr", Instr_ID2, word_at(32'hFFFF_FFFC));
            check_eq("t5_valid", 32'(Valid_ID2), 32'd1);
            check_eq("t5_next_addr", IM_addr2, 32'd0);
         end
      end

      // T2: two-cycle stall at the ack of 0x10
      pc_en_v = 1'b0; ifid_en_v = 1'b0;
      tick();
      check_eq("t2_addr", IM_addr, 32'h10);
      tick();
      check_eq("t2_req_buf", 32'(IM_req), 32'd0);
      check_eq("t2_busy_buf", 32'(Fetch_busy), 32'd0);
      check_eq("t2_hold_instr", Instr_ID, word_at(32'hC));
      pc_en_v = 1'b1; ifid_en_v = 1'b1;
      tick();
      check_eq("t2_req_buf2", 32'(IM_req), 32'd0);
      check_eq("t2_hold_instr2", Instr_ID, word_at(32'hC));
      tick();
      check_eq("t2_release_instr", Instr_ID, word_at(32'h10));
      check_eq("t2_next_addr", IM_addr, 32'h14);
      tick(); tick();

      // T3: redirect with a slow outstanding request, then a double redirect
      t_discard(32'h20, 32'h40, 1'b0, 32'h0);
      t_discard(32'h44, 32'h60, 1'b1, 32'h80);

      // T4: Flush beats a stall hold
      pc_en_v = 1'b0; ifid_en_v = 1'b0; flush_v = 1'b1; target_v = 32'h100;
      tick();
      pc_en_v = 1'b1; ifid_en_v = 1'b1; flush_v = 1'b0;
      tick();
      check_eq("t4_valid", 32'(Valid_ID), 32'd0);
      check_eq("t4_instr", Instr_ID, 32'd0);
      check_eq("t4_addr", IM_addr, 32'h100);

      // PC wrap through a redirect
      flush_v = 1'b1; target_v = 32'hFFFF_FFFC;
      tick();
      flush_v = 1'b0;
      tick();
      check_eq("wrap_addr", IM_addr, 32'hFFFF_FFFC);
      tick();
      check_eq("wrap_next_addr", IM_addr, 32'd0);
      check_eq("wrap_pcplus4", PCplus4_ID, 32'd0);

      // T6a: reset while in DISCARD, with a stray ack on the reset edge
      lat = 3; flush_v = 1'b1; target_v = 32'h200;
      tick();
      flush_v = 1'b0; rst_v = 1'b0; stray_v = 1'b1;
      tick();
      check_eq("t6a_in_discard", 32'(Fetch_busy), 32'd1);
      rst_v = 1'b1; stray_v = 1'b0; lat = 1;
      tick();
      check_eq("t6a_addr", IM_addr, 32'd0);
      check_eq("t6a_valid", 32'(Valid_ID), 32'd0);
      check_eq("t6a_req", 32'(IM_req), 32'd1);

      // T6b: reset while in BUF
      tick();
      pc_en_v = 1'b0; ifid_en_v = 1'b0;
      tick();
      rst_v = 1'b0;
      tick();
      check_eq("t6b_in_buf", 32'(IM_req), 32'd0);
      rst_v = 1'b1; pc_en_v = 1'b1; ifid_en_v = 1'b1;
      tick();
      check_eq("t6b_addr", IM_addr, 32'd0);
      check_eq("t6b_valid", 32'(Valid_ID), 32'd0);
      check_eq("t6b_req", 32'(IM_req), 32'd1);

      tick();
      lat = 50;
      tick();
      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
